// File: rtl/func_pkg.sv
// ---------------------------------------------------------------------------
// func_pkg
// Shared definitions for the func polynomial evaluator and its requester
// (func_min_search): sweep FSM state encoding and the Q-format constants.
//   X operands are Q24.8 (X_W bits), Y results are Q56.8 (Y_W bits).
// ---------------------------------------------------------------------------
package func_pkg;

  localparam int FRAC_BITS = 8;
  localparam int X_W       = 32;
  localparam int Y_W       = 64;

  // Largest positive Q56.8 value; the "no minimum found yet" sentinel.
  localparam logic [Y_W-1:0] Y_MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;

  // 1.0 in Q24.8.
  localparam logic [X_W-1:0] Q_ONE = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/func_min_search_min_tracker.sv
// ---------------------------------------------------------------------------
// min_tracker
// Registered running minimum / argmin over a stream of func samples.
//   clk, rst_n   clock, async active-low reset
//   clear_i      restart tracking (new sweep)
//   sample_i     a result is presented this cycle
//   ovf_i        result overflowed; excluded from the comparison
//   y_i          Q56.8 result, signed
//   x_i, k_i     operand and index that produced y_i
//   valid_o      at least one non-overflowed sample has been taken
//   y_min_o, x_min_o, idx_min_o   current minimum and where it occurred
// Compare is signed strict-less, so ties keep the earliest index.
// ---------------------------------------------------------------------------
module min_tracker
  import func_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic             ovf_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [CNT_W-1:0] k_i,
  output logic             valid_o,
  output logic [Y_W-1:0]   y_min_o,
  output logic [X_W-1:0]   x_min_o,
  output logic [CNT_W-1:0] idx_min_o
);

  logic             valid_q;
  logic [Y_W-1:0]   y_min_q;
  logic [X_W-1:0]   x_min_q;
  logic [CNT_W-1:0] idx_min_q;
  logic             take;

  assign take = sample_i && !ovf_i && ($signed(y_i) < $signed(y_min_q));

  // NOTE: sequential state uses non-blocking (<=) so every register in the
  // block updates from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      y_min_q   <= Y_MAX_POS;
      x_min_q   <= '0;
      idx_min_q <= '0;
    end else if (clear_i) begin
      valid_q   <= 1'b0;
      y_min_q   <= Y_MAX_POS;
      x_min_q   <= '0;
      idx_min_q <= '0;
    end else if (take) begin
      valid_q   <= 1'b1;
      y_min_q   <= y_i;
      x_min_q   <= x_i;
      idx_min_q <= k_i;
    end
  end

  assign valid_o   = valid_q;
  assign y_min_o   = y_min_q;
  assign x_min_o   = x_min_q;
  assign idx_min_o = idx_min_q;

endmodule

// File: rtl/func_min_search.sv
// ---------------------------------------------------------------------------
// func_min_search
// Sweeps N_POINTS operands x = X_START + k*X_STEP (Q24.8) through func using
// a four-phase start_func/func_done handshake and reports the minimum
// non-overflowed y (Q56.8) with its x and index.
//   clk, rst_n        clock, async active-low reset
//   start             sweep request (ignored while busy)
//   busy, done        sweep in progress / one-cycle end pulse
//   valid             min outputs hold a real sample
//   timeout_err       sweep aborted waiting on func_done (sticky)
//   ovf_seen          some sample overflowed (sticky)
//   x_min, y_min, idx_min   minimum and its location
//   start_func, x_out       request and operand to func
//   y_in, func_done, overflow   response from func
// ---------------------------------------------------------------------------
module func_min_search
  import func_pkg::*;
#(
  parameter logic [X_W-1:0] X_START  = 32'hFFFF_FC00,
  parameter logic [X_W-1:0] X_STEP   = 32'h0000_0100,
  parameter int             N_POINTS = 16,
  parameter int             CNT_W    = 8,
  parameter int             TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             timeout_err,
  output logic             ovf_seen,
  output logic [X_W-1:0]   x_min,
  output logic [Y_W-1:0]   y_min,
  output logic [CNT_W-1:0] idx_min,
  output logic             start_func,
  output logic [X_W-1:0]   x_out,
  input  logic [Y_W-1:0]   y_in,
  input  logic             func_done,
  input  logic             overflow
);

  localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  K_LAST    = CNT_W'(N_POINTS - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_err_q;
  logic              ovf_seen_q;
  logic              start_func_q;
  logic [X_W-1:0]    x_out_q;
  logic [CNT_W-1:0]  k_q;
  logic [WAIT_W-1:0] wait_q;

  logic clear;
  logic sample;

  assign clear  = (state_q == ST_IDLE) && start;
  assign sample = (state_q == ST_REQ) && func_done;

  min_tracker #(
    .CNT_W(CNT_W)
  ) u_min_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear),
    .sample_i (sample),
    .ovf_i    (overflow),
    .y_i      (y_in),
    .x_i      (x_out_q),
    .k_i      (k_q),
    .valid_o  (valid),
    .y_min_o  (y_min),
    .x_min_o  (x_min),
    .idx_min_o(idx_min)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_seen_q    <= 1'b0;
      start_func_q  <= 1'b0;
      x_out_q       <= '0;
      k_q           <= '0;
      wait_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q        <= 1'b1;
            k_q           <= '0;
            x_out_q       <= X_START;
            ovf_seen_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_q        <= '0;
            state_q       <= ST_REQ;
          end
        end

        // start_func goes high on the first REQ cycle's edge, so it is seen
        // one cycle after REQ entry; func_done is known low here.
        ST_REQ: begin
          if (func_done) begin
            start_func_q <= 1'b0;
            if (overflow) ovf_seen_q <= 1'b1;
            wait_q       <= '0;
            state_q      <= ST_RELEASE;
          end else if (wait_q == WAIT_LAST) begin
            timeout_err_q <= 1'b1;
            start_func_q  <= 1'b0;
            wait_q        <= '0;
            state_q       <= ST_FINISH;
          end else begin
            start_func_q <= 1'b1;
            wait_q       <= wait_q + 1'b1;
          end
        end

        // x_out only moves here, while start_func is low.
        ST_RELEASE: begin
          if (!func_done) begin
            wait_q <= '0;
            if (k_q == K_LAST) begin
              state_q <= ST_FINISH;
            end else begin
              k_q     <= k_q + 1'b1;
              x_out_q <= x_out_q + X_STEP;
              state_q <= ST_REQ;
            end
          end else if (wait_q == WAIT_LAST) begin
            timeout_err_q <= 1'b1;
            wait_q        <= '0;
            state_q       <= ST_FINISH;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign ovf_seen    = ovf_seen_q;
  assign start_func  = start_func_q;
  assign x_out       = x_out_q;

endmodule
